// File: rtl/wb_master_if_pkg.sv
// Shared constants and FSM state encoding for the Wishbone classic master port.
package wb_master_if_pkg;

    localparam int          RegBus     = 32;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;

    typedef enum logic [1:0] {
        WB_IDLE       = 2'd0,
        WB_BUSY       = 2'd1,
        WB_WAIT_STALL = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_master_if.sv
// Wishbone classic single-cycle master: one CPU request becomes one bus cycle.
// Optional WB_TIMEOUT_EN adds a BUSY watchdog that aborts with a bus_err_o pulse.
module wb_master_if
    import wb_master_if_pkg::*;
#(
    parameter int STALL_W        = 6,
    parameter int STALL_IDX      = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [31:0]        cpu_data_i,
    input  logic [3:0]         cpu_sel_i,
    output logic [31:0]        cpu_data_o,
    output logic               stallreq_o,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    output logic               bus_err_o,
    output logic [31:0]        wb_adr_o,
    output logic [31:0]        wb_dat_o,
    input  logic [31:0]        wb_dat_i,
    output logic [3:0]         wb_sel_o,
    output logic               wb_we_o,
    output logic               wb_stb_o,
    output logic               wb_cyc_o,
    input  logic               wb_ack_i
);

    wb_state_e         state_q, state_d;
    logic [RegBus-1:0] adr_q, adr_d, dat_q, dat_d, rd_buf_q, rd_buf_d;
    logic [3:0]        sel_q, sel_d;
    logic              we_q, we_d, stb_q, stb_d, cyc_q, cyc_d;
    logic              bus_err_d;
    logic              timeout;
    logic              stage_stall;
    logic              unused_cfg;

    assign stage_stall = stall_i[STALL_IDX];
    assign unused_cfg  = ^{stall_i, 8'(TIMEOUT_CYCLES)};

`ifdef WB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q;
    logic       bus_err_q;

    // Held at zero outside BUSY, so every new cycle starts counting from zero.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state_q != WB_BUSY) begin
            cnt_q <= 8'd0;
        end else if (!wb_ack_i) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end

    assign timeout   = (cnt_q == TO_LAST);
    assign bus_err_o = bus_err_q;
`else
    assign timeout   = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= WB_IDLE;
            adr_q    <= ZeroWord;
            dat_q    <= ZeroWord;
            sel_q    <= 4'h0;
            we_q     <= 1'b0;
            stb_q    <= 1'b0;
            cyc_q    <= 1'b0;
            rd_buf_q <= ZeroWord;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            stb_q    <= stb_d;
            cyc_q    <= cyc_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        stb_d     = stb_q;
        cyc_d     = cyc_q;
        rd_buf_d  = rd_buf_q;
        bus_err_d = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    adr_d   = cpu_addr_i;
                    dat_d   = cpu_data_i;
                    sel_d   = cpu_sel_i;
                    we_d    = cpu_we_i;
                    stb_d   = 1'b1;
                    cyc_d   = 1'b1;
                    state_d = WB_BUSY;
                end
            end
            WB_BUSY: begin
                if (wb_ack_i) begin
                    // Ack beats a simultaneous flush: the slave has already committed.
                    adr_d = ZeroWord;
                    sel_d = 4'h0;
                    we_d  = 1'b0;
                    stb_d = 1'b0;
                    cyc_d = 1'b0;
                    if (!we_q) begin
                        rd_buf_d = wb_dat_i;
                    end
                    state_d = (stage_stall && !flush_i) ? WB_WAIT_STALL : WB_IDLE;
                end else if (flush_i || timeout) begin
                    adr_d     = ZeroWord;
                    dat_d     = ZeroWord;
                    sel_d     = 4'h0;
                    we_d      = 1'b0;
                    stb_d     = 1'b0;
                    cyc_d     = 1'b0;
                    rd_buf_d  = ZeroWord;
                    bus_err_d = !flush_i;
                    state_d   = (!flush_i && stage_stall) ? WB_WAIT_STALL : WB_IDLE;
                end
            end
            WB_WAIT_STALL: begin
                if (!stage_stall || flush_i) begin
                    state_d = WB_IDLE;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = ZeroWord;
        case (state_q)
            WB_IDLE: stallreq_o = cpu_ce_i && !flush_i;
            WB_BUSY: begin
                stallreq_o = !wb_ack_i && !flush_i;
                if (wb_ack_i && !we_q) begin
                    cpu_data_o = wb_dat_i;
                end
            end
            WB_WAIT_STALL: cpu_data_o = rd_buf_q;
            default: ;
        endcase
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_stb_o = stb_q;
    assign wb_cyc_o = cyc_q;

endmodule

// File: tb/tb_wb_master_if.sv
// Scenario bench for wb_master_if; expected bus fields and load data come from a scoreboard queue.
module tb_wb_master_if;
    import wb_master_if_pkg::*;

`ifdef WB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce, cpu_we, flush, bus_err, stallreq;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_sel;
    logic [5:0]  stall;
    logic [31:0] wb_adr, wb_dat_out, wb_dat_in;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_stb, wb_cyc, wb_ack;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] rdata;
    } txn_t;

    txn_t sb[$];
    txn_t t;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    wb_master_if #(.STALL_W(6), .STALL_IDX(0), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cpu_ce_i(cpu_ce), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
        .cpu_sel_i(cpu_sel), .cpu_data_o(cpu_rdata), .stallreq_o(stallreq),
        .stall_i(stall), .flush_i(flush), .bus_err_o(bus_err),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_out), .wb_dat_i(wb_dat_in), .wb_sel_o(wb_sel),
        .wb_we_o(wb_we), .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc), .wb_ack_i(wb_ack)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        cpu_ce = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_sel = 0;
        stall = 0; flush = 0; wb_ack = 0; wb_dat_in = 0;
    endtask

    task automatic start_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic [31:0] rdata);
        txn_t n;
        n.we = we; n.adr = adr; n.dat = dat; n.sel = sel; n.rdata = rdata;
        sb.push_back(n);
        cpu_ce = 1; cpu_we = we; cpu_addr = adr; cpu_wdata = dat; cpu_sel = sel;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        cpu_ce = 1; cpu_addr = 32'h1234;
        step(); step();
        #1;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) $display("FAIL reset_cyc_stb got=%b%b want=00", wb_cyc, wb_stb);
        else n_pass++;
        n_checks++;
        if (wb_adr !== 32'h0 || wb_sel !== 4'h0 || wb_we !== 1'b0) $display("FAIL reset_bus got adr=%h sel=%h we=%b want 0", wb_adr, wb_sel, wb_we);
        else n_pass++;
        n_checks++;
        if (bus_err !== 1'b0 || cpu_rdata !== ZeroWord) $display("FAIL reset_err_data got err=%b data=%h want 0", bus_err, cpu_rdata);
        else n_pass++;
        n_checks++;
        cpu_ce = 0; cpu_addr = 0;
        rst = 0;
        step();
        #1;
        if (stallreq !== 1'b0 || wb_cyc !== 1'b0) $display("FAIL reset_release got stallreq=%b cyc=%b want 0", stallreq, wb_cyc);
        else n_pass++;
        n_checks++;
        $display("txn reset done");
    endtask

    task automatic test_load();
        int stall_cnt = 0;
        start_req(1'b0, CLINT_BASE + 32'hbff8, 32'h0, 4'hF, 32'h0000_0123);
        #1; if (stallreq === 1'b1) stall_cnt++;
        step(); cpu_ce = 0; #1;
        if (stallreq === 1'b1) stall_cnt++;
        t = sb[0];
        if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || wb_adr !== t.adr || wb_we !== t.we || wb_sel !== t.sel)
            $display("FAIL load_bus got cyc=%b stb=%b adr=%h we=%b sel=%h want 1 1 %h %b %h", wb_cyc, wb_stb, wb_adr, wb_we, wb_sel, t.adr, t.we, t.sel);
        else n_pass++;
        n_checks++;
        step(); wb_ack = 1; wb_dat_in = t.rdata; #1;
        if (stallreq === 1'b1) stall_cnt++;
        if (cpu_rdata !== t.rdata) $display("FAIL load_data got=%h want=%h", cpu_rdata, t.rdata);
        else n_pass++;
        n_checks++;
        void'(sb.pop_front());
        step(); wb_ack = 0; wb_dat_in = 0; #1;
        if (stallreq === 1'b1) stall_cnt++;
        if (wb_cyc !== 1'b0) $display("FAIL load_cyc_drop got=%b want=0", wb_cyc);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== 2) $display("FAIL load_stall_cycles got=%0d want=2", stall_cnt);
        else n_pass++;
        n_checks++;
        $display("txn load adr=%h data=%h", t.adr, t.rdata);
    endtask

    task automatic test_store();
        start_req(1'b1, CLINT_BASE + 32'h4000, 32'h0000_0050, 4'hF, 32'h0);
        step(); cpu_ce = 0; cpu_wdata = 32'hFFFF_FFFF; #1;
        t = sb[0];
        if (wb_we !== 1'b1 || wb_dat_out !== t.dat || wb_adr !== t.adr || wb_sel !== t.sel || wb_stb !== 1'b1)
            $display("FAIL store_bus got we=%b dat=%h adr=%h sel=%h stb=%b want 1 %h %h %h 1", wb_we, wb_dat_out, wb_adr, wb_sel, wb_stb, t.dat, t.adr, t.sel);
        else n_pass++;
        n_checks++;
        step(); wb_ack = 1; wb_dat_in = 32'hBEEF; #1;
        if (wb_cyc !== 1'b1 || cpu_rdata !== ZeroWord) $display("FAIL store_ack_cycle got cyc=%b data=%h want 1 0", wb_cyc, cpu_rdata);
        else n_pass++;
        n_checks++;
        void'(sb.pop_front());
        step(); wb_ack = 0; wb_dat_in = 0; cpu_wdata = 0; #1;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_we !== 1'b0) $display("FAIL store_cyc_drop got cyc=%b stb=%b we=%b want 000", wb_cyc, wb_stb, wb_we);
        else n_pass++;
        n_checks++;
        $display("txn store adr=%h data=%h", t.adr, t.dat);
    endtask

    task automatic test_stall_ack();
        start_req(1'b0, CLINT_BASE + 32'h0008, 32'h0, 4'hF, 32'hCAFE_0042);
        step(); cpu_ce = 0;
        t = sb[0];
        step(); wb_ack = 1; wb_dat_in = t.rdata; stall = 6'b000001; #1;
        if (cpu_rdata !== t.rdata) $display("FAIL stall_ack_data got=%h want=%h", cpu_rdata, t.rdata);
        else n_pass++;
        n_checks++;
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            step(); wb_ack = 0; wb_dat_in = 32'hDEAD_0000;
            if (i == 2) stall = 0;
            #1;
            if (cpu_rdata !== t.rdata || wb_cyc !== 1'b0 || stallreq !== 1'b0)
                $display("FAIL stall_hold[%0d] got data=%h cyc=%b stallreq=%b want %h 0 0", i, cpu_rdata, wb_cyc, stallreq, t.rdata);
            else n_pass++;
            n_checks++;
        end
        step(); wb_dat_in = 0; #1;
        if (cpu_rdata !== ZeroWord) $display("FAIL stall_release got=%h want=0", cpu_rdata);
        else n_pass++;
        n_checks++;
        $display("txn stalled load adr=%h data=%h", t.adr, t.rdata);
    endtask

    task automatic test_flush();
        start_req(1'b0, CLINT_BASE + 32'h0010, 32'h0, 4'h3, 32'h0);
        step(); cpu_ce = 0; flush = 1; #1;
        if (stallreq !== 1'b0 || wb_stb !== 1'b1) $display("FAIL flush_busy got stallreq=%b stb=%b want 0 1", stallreq, wb_stb);
        else n_pass++;
        n_checks++;
        step(); flush = 0; #1;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_adr !== 32'h0) $display("FAIL flush_abort got cyc=%b stb=%b adr=%h want 0 0 0", wb_cyc, wb_stb, wb_adr);
        else n_pass++;
        n_checks++;
        wb_ack = 1; wb_dat_in = 32'h777; #1;
        if (cpu_rdata !== ZeroWord || stallreq !== 1'b0) $display("FAIL flush_late_ack got data=%h stallreq=%b want 0 0", cpu_rdata, stallreq);
        else n_pass++;
        n_checks++;
        step(); wb_ack = 0; wb_dat_in = 0; #1;
        if (wb_cyc !== 1'b0) $display("FAIL flush_no_restart got cyc=%b want 0", wb_cyc);
        else n_pass++;
        n_checks++;
        t = sb.pop_front();
        $display("txn flushed load adr=%h", t.adr);
    endtask

    task automatic test_ack_flush();
        start_req(1'b1, CLINT_BASE + 32'h4004, 32'h0000_00A5, 4'hF, 32'h0);
        step(); cpu_ce = 0; #1;
        t = sb[0];
        if (wb_we !== 1'b1 || wb_dat_out !== t.dat) $display("FAIL ackflush_bus got we=%b dat=%h want 1 %h", wb_we, wb_dat_out, t.dat);
        else n_pass++;
        n_checks++;
        step(); wb_ack = 1; flush = 1; #1;
        void'(sb.pop_front());
        step(); wb_ack = 0; flush = 0; #1;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) $display("FAIL ackflush_end got cyc=%b stb=%b want 00", wb_cyc, wb_stb);
        else n_pass++;
        n_checks++;
        step(); #1;
        if (wb_cyc !== 1'b0 || stallreq !== 1'b0 || cpu_rdata !== ZeroWord) $display("FAIL ackflush_no_second got cyc=%b stallreq=%b data=%h want 0 0 0", wb_cyc, stallreq, cpu_rdata);
        else n_pass++;
        n_checks++;
        $display("txn store with flush adr=%h data=%h", t.adr, t.dat);
    endtask

    task automatic test_back_to_back();
        start_req(1'b0, CLINT_BASE + 32'h0020, 32'h0, 4'hF, 32'h0000_0011);
        step(); t = sb[0];
        step(); wb_ack = 1; wb_dat_in = t.rdata; #1;
        if (cpu_rdata !== t.rdata) $display("FAIL b2b_first got=%h want=%h", cpu_rdata, t.rdata);
        else n_pass++;
        n_checks++;
        void'(sb.pop_front());
        $display("txn b2b load adr=%h data=%h", t.adr, t.rdata);
        start_req(1'b0, CLINT_BASE + 32'h0024, 32'h0, 4'hF, 32'h0000_0022);
        step(); wb_ack = 0; wb_dat_in = 0; #1;
        if (wb_cyc !== 1'b0 || stallreq !== 1'b1) $display("FAIL b2b_gap got cyc=%b stallreq=%b want 0 1", wb_cyc, stallreq);
        else n_pass++;
        n_checks++;
        step(); cpu_ce = 0; #1;
        t = sb[0];
        if (wb_cyc !== 1'b1 || wb_adr !== t.adr) $display("FAIL b2b_second_bus got cyc=%b adr=%h want 1 %h", wb_cyc, wb_adr, t.adr);
        else n_pass++;
        n_checks++;
        step(); wb_ack = 1; wb_dat_in = t.rdata; #1;
        if (cpu_rdata !== t.rdata) $display("FAIL b2b_second got=%h want=%h", cpu_rdata, t.rdata);
        else n_pass++;
        n_checks++;
        void'(sb.pop_front());
        step(); wb_ack = 0; wb_dat_in = 0;
        $display("txn b2b load adr=%h data=%h", t.adr, t.rdata);
    endtask

    task automatic test_reset_mid();
        start_req(1'b0, CLINT_BASE + 32'h0030, 32'h0, 4'hF, 32'h0);
        step(); cpu_ce = 0; rst = 1;
        step(); rst = 0; #1;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) $display("FAIL rstmid_drop got cyc=%b stb=%b want 00", wb_cyc, wb_stb);
        else n_pass++;
        n_checks++;
        wb_ack = 1; wb_dat_in = 32'h55; #1;
        if (cpu_rdata !== ZeroWord || stallreq !== 1'b0) $display("FAIL rstmid_late_ack got data=%h stallreq=%b want 0 0", cpu_rdata, stallreq);
        else n_pass++;
        n_checks++;
        step(); wb_ack = 0; wb_dat_in = 0; #1;
        if (wb_cyc !== 1'b0) $display("FAIL rstmid_idle got cyc=%b want 0", wb_cyc);
        else n_pass++;
        n_checks++;
        t = sb.pop_front();
        $display("txn reset-aborted load adr=%h", t.adr);
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout();
        int err_at  = -1;
        int err_cnt = 0;
        start_req(1'b0, CLINT_BASE + 32'h0040, 32'h0, 4'hF, 32'h0);
        step(); cpu_ce = 0;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (bus_err === 1'b1) begin
                err_cnt++;
                if (err_at < 0) err_at = i;
                if (wb_cyc !== 1'b0 || cpu_rdata !== ZeroWord || stallreq !== 1'b0)
                    $display("FAIL timeout_state got cyc=%b data=%h stallreq=%b want 0 0 0", wb_cyc, cpu_rdata, stallreq);
                else n_pass++;
                n_checks++;
            end
            step();
        end
        if (err_at !== 5) $display("FAIL timeout_cycle got=%0d want=5", err_at);
        else n_pass++;
        n_checks++;
        if (err_cnt !== 1) $display("FAIL timeout_pulses got=%0d want=1", err_cnt);
        else n_pass++;
        n_checks++;
        t = sb.pop_front();
        $display("txn timed-out load adr=%h", t.adr);
    endtask
`else
    task automatic test_no_timeout();
        int err_seen = 0;
        start_req(1'b0, CLINT_BASE + 32'h0040, 32'h0, 4'hF, 32'h0);
        step(); cpu_ce = 0;
        for (int i = 0; i < 30; i++) begin
            #1; if (bus_err !== 1'b0) err_seen++;
            step();
        end
        if (wb_cyc !== 1'b1 || stallreq !== 1'b1 || err_seen !== 0)
            $display("FAIL no_timeout_wait got cyc=%b stallreq=%b errs=%0d want 1 1 0", wb_cyc, stallreq, err_seen);
        else n_pass++;
        n_checks++;
        flush = 1;
        step(); flush = 0; #1;
        if (wb_cyc !== 1'b0) $display("FAIL no_timeout_flush got cyc=%b want 0", wb_cyc);
        else n_pass++;
        n_checks++;
        t = sb.pop_front();
        $display("txn unacked load flushed adr=%h", t.adr);
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_store();
        test_stall_ack();
        test_flush();
        test_ack_flush();
        test_back_to_back();
        test_reset_mid();
`ifdef WB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        if (sb.size() !== 0) $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        else n_pass++;
        n_checks++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
